imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path. It takes a byte stream from a host/debug link, packs it into 32-bit instruction words and writes them into instruction SRAM.
- Addresses are byte addresses starting at BASE_ADDR and stepping by 4, which is the same addressing the fetch unit reads back.
- The stream carries a word-count header and ends with an XOR checksum.
- On success, cpu_run is asserted to release the CPU; on failure, the block holds the CPU stopped.

---
 rtl/loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 47 ++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader.
// State encoding and byte-lane sizing.
package loader_pkg;

  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream into big-endian 32-bit words.
// word/word_valid are valid in the cycle the 4th byte is accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;
  logic              accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (accept) begin
      lane_d  = lane_q + LANE_W'(1);
      shift_d = {shift_q[15:0], in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word       = {shift_q, in_data};
  assign word_valid = accept & (&lane_q) & ~clear;

endmodule

// File: rtl/imem_loader.sv
// Streams header, words and checksum into instruction SRAM,
// then releases the CPU on a good checksum.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_run,
  output logic [CNT_W-1:0] words_loaded
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [31:0]      csum_q, csum_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;

  logic [31:0] word;
  logic        wv;
  logic        idle_like;
  logic        clear;
  logic        hdr_bad;
  logic        last;

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE) ||
                     (state_q == S_ERR);
  assign clear   = start & idle_like;
  assign hdr_bad = (word == 32'd0) ||
                   (word > 32'(MAX_WORDS));
  assign last    = (cnt_q + CNT_W'(1)) == n_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .word       (word),
    .word_valid (wv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      csum_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_d = S_HDR;
      S_HDR:
        if (wv) state_d = hdr_bad ? S_ERR : S_LOAD;
      S_LOAD:
        if (wv && last) state_d = S_CSUM;
      S_CSUM:
        if (wv) state_d = (word == csum_q) ? S_DONE : S_ERR;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Word k is registered on its 4th-byte edge; the write
  // pulse, checksum and count all show in the next cycle.
  always_comb begin
    cnt_d   = cnt_q;
    n_d     = n_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      n_d    = '0;
      csum_d = '0;
    end else if (wv && state_q == S_HDR && !hdr_bad) begin
      n_d = word[CNT_W-1:0];
    end else if (wv && state_q == S_LOAD) begin
      we_d    = 1'b1;
      addr_d  = BASE_ADDR + (32'(cnt_q) << 2);
      wdata_d = word;
      csum_d  = csum_q ^ word;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    busy     = (state_q == S_HDR) ||
               (state_q == S_LOAD) ||
               (state_q == S_CSUM);
    in_ready = busy;
    done     = (state_q == S_DONE);
    cpu_run  = (state_q == S_DONE);
    error    = (state_q == S_ERR);
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader with a
// stream-level reference model of writes and final flags.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;
  localparam int          CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, error, cpu_run;
  logic [CW-1:0] words_loaded;

  int tests = 0;
  int fails = 0;

  logic [63:0] got[$];
  logic [31:0] ws[$];

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded)
  );

  always @(negedge clk)
    if (rst_n && mem_we) got.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int maxgap,
                           input bit st);
    int g = 0;
    int gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 50) begin
      tests++; fails++;
      $error("FAIL byte_timeout observed=0 expected=1");
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int maxgap,
                           input bit st);
    for (int i = 3; i >= 0; i--)
      send_byte(w[8*i +: 8], maxgap, st && (i == 3));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference: a legal header yields one write per word at
  // BASE+4k; success iff the checksum equals the XOR of words.
  task automatic check_session(input string tag,
                               input logic [31:0] hdr,
                               input logic [31:0] c);
    bit          ok_hdr = (hdr != 0) && (hdr <= MAXW);
    int          nexp = ok_hdr ? int'(hdr) : 0;
    logic [31:0] x = 32'd0;
    bit          pass;
    foreach (ws[i]) x ^= ws[i];
    pass = ok_hdr && (x == c);
    check({tag, "_nwr"}, got.size(), nexp);
    for (int i = 0; i < nexp && i < got.size(); i++) begin
      check({tag, "_addr"}, got[i][63:32], BASE + 32'(4 * i));
      check({tag, "_data"}, got[i][31:0], ws[i]);
    end
    check({tag, "_done"}, done, pass);
    check({tag, "_cpu_run"}, cpu_run, pass);
    check({tag, "_error"}, error, !pass);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_wl"}, words_loaded, nexp);
  endtask

  task automatic run_session(input string tag,
                             input logic [31:0] hdr,
                             input logic [31:0] c,
                             input int maxgap,
                             input bit starts);
    got.delete();
    pulse_start();
    check({tag, "_busy_start"}, busy, 1);
    send_word(hdr, maxgap, 1'b0);
    if (hdr != 0 && hdr <= MAXW) begin
      foreach (ws[k])
        send_word(ws[k], maxgap,
                  starts && (k == 0 || $urandom_range(0, 1) == 1));
      send_word(c, maxgap, 1'b0);
    end
    in_valid = 1'b0;
    check_session(tag, hdr, c);
  endtask

  initial begin
    #2;
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 0);
    check("rst_flags", {busy, done, error, cpu_run}, 0);
    check("rst_wl", words_loaded, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    ws = '{32'h2008_0005, 32'h2009_000A};
    run_session("happy", 32'd2, 32'h0001_000F, 0, 1'b0);
    run_session("badcs", 32'd2, 32'h0001_000E, 0, 1'b0);

    ws.delete();
    run_session("hdr0", 32'd0, 32'd0, 0, 1'b0);
    run_session("hdrmax", MAXW + 1, 32'd0, 0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("hdr_nowr", got.size(), 0);

    ws = '{32'h2008_0005, 32'h2009_000A};
    for (int r = 0; r < 3; r++)
      run_session("gaps", 32'd2, 32'h0001_000F, 5, 1'b1);

    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 6);
      logic [31:0] x;
      ws.delete();
      x = 0;
      for (int k = 0; k < n; k++) begin
        ws.push_back($urandom);
        x ^= ws[k];
      end
      if ($urandom_range(0, 1) == 1) x ^= 32'h0000_0100;
      run_session("rand", 32'(n), x, 3, 1'b1);
    end

    ws = '{32'h2008_0005, 32'h2009_000A};
    got.delete();
    pulse_start();
    send_word(32'd2, 0, 1'b0);
    send_word(ws[0], 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    send_byte(8'h09, 0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_we", mem_we, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_flags", {busy, done, error, cpu_run}, 0);
    check("mrst_addr", mem_addr, BASE);
    check("mrst_wdata", mem_wdata, 0);
    check("mrst_wl", words_loaded, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("mrst_nwr", got.size(), 1);
    run_session("after_rst", 32'd2, 32'h0001_000F, 0, 1'b0);

    ws = '{32'hDEAD_BEEF};
    got.delete();
    pulse_start();
    check("restart_done", done, 0);
    check("restart_run", cpu_run, 0);
    send_word(32'd1, 0, 1'b0);
    send_word(ws[0], 0, 1'b0);
    send_word(32'hDEAD_BEEF, 0, 1'b0);
    in_valid = 1'b0;
    check_session("restart", 32'd1, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
